// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and constants for the sequential input router
//                address-generation stage.
//                  - wag_state_e         : window address generator FSM states
//                  - DEFAULT_KERNEL_SIZE : default convolution kernel side K
//                  - STRIDE_W            : width of the stride field (S = 1..3)
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Default kernel side used by the address generator and its counter.
    localparam int DEFAULT_KERNEL_SIZE = 3;

    // Stride is carried on a 2-bit field; 0 is an illegal configuration.
    localparam int STRIDE_W = 2;

    // Window address generator states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } wag_state_e;

endpackage : router_pkg
`default_nettype wire

// File: rtl/ofmap_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ofmap_pos_counter
//  Description : Output-feature-map position counter. Holds the top-left
//                corner (pos_r, pos_c) of the current KxK window and steps it
//                in raster order by the stride S, truncating positions whose
//                window would run past the tile edge.
//  Ports       : i_clk      - clock
//                i_rst      - synchronous active-high reset (position -> 0,0)
//                i_load     - restart at position (0,0)
//                i_step     - advance to the next window position
//                i_i_size   - tile side I
//                i_stride   - stride S
//                o_pos_r    - current window row
//                o_pos_c    - current window column
//                o_last     - current position is the final one of the tile
//  Revision    : 1.0 - initial release
// ============================================================================
module ofmap_pos_counter
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [STRIDE_W-1:0]   i_stride,
    output logic [ADDR_WIDTH-1:0] o_pos_r,
    output logic [ADDR_WIDTH-1:0] o_pos_c,
    output logic                  o_last
);

    // Headroom for pos + S + K so the edge comparisons cannot wrap.
    localparam int c_SUM_W = ADDR_WIDTH + 3;

    logic [ADDR_WIDTH-1:0] pos_r_q, pos_r_d;
    logic [ADDR_WIDTH-1:0] pos_c_q, pos_c_d;
    logic [c_SUM_W-1:0]    w_col_reach;
    logic [c_SUM_W-1:0]    w_row_reach;
    logic                  w_col_wrap;
    logic                  w_row_wrap;

    // A further step along an axis is only legal if the window placed there
    // still fits inside the tile: next_pos + K <= I.
    always_comb begin
        w_col_reach = c_SUM_W'(pos_c_q) + c_SUM_W'(i_stride) + c_SUM_W'(KERNEL_SIZE);
        w_row_reach = c_SUM_W'(pos_r_q) + c_SUM_W'(i_stride) + c_SUM_W'(KERNEL_SIZE);
        w_col_wrap  = (w_col_reach > c_SUM_W'(i_i_size));
        w_row_wrap  = (w_row_reach > c_SUM_W'(i_i_size));
        o_last      = w_col_wrap & w_row_wrap;
    end

    always_comb begin
        pos_r_d = pos_r_q;
        pos_c_d = pos_c_q;
        if (i_load) begin
            pos_r_d = '0;
            pos_c_d = '0;
        end else if (i_step) begin
            if (w_col_wrap) begin
                pos_c_d = '0;
                pos_r_d = pos_r_q + ADDR_WIDTH'(i_stride);
            end else begin
                pos_c_d = pos_c_q + ADDR_WIDTH'(i_stride);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos_r_q <= '0;
            pos_c_q <= '0;
        end else begin
            pos_r_q <= pos_r_d;
            pos_c_q <= pos_c_d;
        end
    end

    assign o_pos_r = pos_r_q;
    assign o_pos_c = pos_c_q;

endmodule : ofmap_pos_counter
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window_addr_gen
//  Description : Window address generator feeding the row group. For every
//                output pixel of a KxK convolution over a square row-major
//                tile it emits ADDR_LENGTH tile addresses plus the id of the
//                receiving row router (round-robin), with valid/ready
//                backpressure and a one-cycle done pulse.
//  Ports       : i_clk        - clock
//                i_rst        - synchronous active-high reset
//                i_reg_clear  - synchronous soft clear (same effect as reset)
//                i_start      - start pulse, honoured only in IDLE
//                i_i_size     - tile side I (latched at start)
//                i_stride     - stride S (latched at start)
//                i_ready      - downstream accepts the current window
//                o_ag_addr    - window addresses, entry 0 = top-left
//                o_ag_valid   - window valid
//                o_row_id     - binary index of the receiving row router
//                o_busy       - generating windows
//                o_done       - one-cycle end-of-run pulse
//                o_cfg_err    - sticky configuration error
//  Revision    : 1.0 - initial release
// ============================================================================
module window_addr_gen
    import router_pkg::*;
#(
    parameter int ROUTER_COUNT = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int KERNEL_SIZE  = DEFAULT_KERNEL_SIZE,
    parameter int ADDR_LENGTH  = 9
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_reg_clear,
    input  logic                                    i_start,
    input  logic [ADDR_WIDTH-1:0]                   i_i_size,
    input  logic [STRIDE_W-1:0]                     i_stride,
    input  logic                                    i_ready,
    output logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]  o_ag_addr,
    output logic                                    o_ag_valid,
    output logic [ROUTER_COUNT-1:0]                 o_row_id,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_cfg_err
);

    generate
        if (ADDR_LENGTH != KERNEL_SIZE * KERNEL_SIZE) begin : g_len_check
            $error("window_addr_gen: ADDR_LENGTH must equal KERNEL_SIZE*KERNEL_SIZE");
        end
    endgenerate

    // I*I is evaluated one bit wider than a full product so the 2**ADDR_WIDTH
    // limit itself is representable.
    localparam int c_SQ_W = 2 * ADDR_WIDTH + 1;

    wag_state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                    i_size_q, i_size_d;
    logic [STRIDE_W-1:0]                      stride_q, stride_d;
    logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                                     valid_q, valid_d;
    logic [ROUTER_COUNT-1:0]                  row_id_q, row_id_d;
    logic                                     last_q, last_d;
    logic                                     cfg_err_q, cfg_err_d;

    logic                                     w_clr;
    logic                                     w_accept;
    logic                                     w_cfg_ok;
    logic [c_SQ_W-1:0]                        w_i_sq;
    logic                                     w_fill;
    logic                                     w_cnt_load;
    logic                                     w_cnt_step;
    logic [ADDR_WIDTH-1:0]                    w_pos_r;
    logic [ADDR_WIDTH-1:0]                    w_pos_c;
    logic                                     w_pos_last;
    logic [ADDR_WIDTH-1:0]                    w_base;
    logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]   w_win;
    logic [ROUTER_COUNT-1:0]                  w_row_id_next;

    assign w_clr    = i_rst | i_reg_clear;
    assign w_accept = valid_q & i_ready;

    // Configuration check on the live inputs, evaluated when start is seen.
    always_comb begin
        w_i_sq   = c_SQ_W'(i_i_size) * c_SQ_W'(i_i_size);
        w_cfg_ok = (i_stride != '0)
                 && (i_i_size >= ADDR_WIDTH'(KERNEL_SIZE))
                 && (w_i_sq <= (c_SQ_W'(1) << ADDR_WIDTH));
    end

    // The position counter always points at the next window to be loaded
    // into the output register. Loading the first window and refilling on
    // every non-final accept keeps one window per cycle with no bubble.
    assign w_fill     = (state_q == GEN) && (!valid_q || (w_accept && !last_q));
    assign w_cnt_load = (state_q == IDLE) && i_start && w_cfg_ok;
    assign w_cnt_step = w_fill && !w_pos_last;

    ofmap_pos_counter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_pos_counter (
        .i_clk    (i_clk),
        .i_rst    (w_clr),
        .i_load   (w_cnt_load),
        .i_step   (w_cnt_step),
        .i_i_size (i_size_q),
        .i_stride (stride_q),
        .o_pos_r  (w_pos_r),
        .o_pos_c  (w_pos_c),
        .o_last   (w_pos_last)
    );

    // Window expansion. The config check guarantees I*I <= 2**ADDR_WIDTH,
    // so truncation to ADDR_WIDTH bits never loses a live address bit.
    always_comb begin
        w_base = ADDR_WIDTH'(w_pos_r * i_size_q) + w_pos_c;
        for (int k = 0; k < ADDR_LENGTH; k++) begin
            w_win[k] = w_base
                     + ADDR_WIDTH'((k / KERNEL_SIZE) * int'(i_size_q))
                     + ADDR_WIDTH'(k % KERNEL_SIZE);
        end
    end

    assign w_row_id_next = (row_id_q == ROUTER_COUNT'(ROUTER_COUNT - 1))
                         ? '0 : row_id_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        i_size_d  = i_size_q;
        stride_d  = stride_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        row_id_d  = row_id_q;
        last_d    = last_q;
        cfg_err_d = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    i_size_d = i_i_size;
                    stride_d = i_stride;
                    row_id_d = '0;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                    if (w_cfg_ok) begin
                        cfg_err_d = 1'b0;
                        state_d   = GEN;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            GEN: begin
                if (w_accept) begin
                    row_id_d = w_row_id_next;
                    if (last_q) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end
                end
                if (w_fill) begin
                    addr_d  = w_win;
                    valid_d = 1'b1;
                    last_d  = w_pos_last;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            state_q   <= IDLE;
            i_size_q  <= '0;
            stride_q  <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            row_id_q  <= '0;
            last_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_size_q  <= i_size_d;
            stride_q  <= stride_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            row_id_q  <= row_id_d;
            last_q    <= last_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign o_ag_addr  = addr_q;
    assign o_ag_valid = valid_q;
    assign o_row_id   = row_id_q;
    assign o_busy     = (state_q == GEN);
    assign o_done     = (state_q == DONE);
    assign o_cfg_err  = cfg_err_q;

endmodule : window_addr_gen
`default_nettype wire

// File: tb/tb_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_addr_gen
//  Description : Self-checking bench for window_addr_gen. A table of run
//                configurations with hand-derived results, hand-written
//                abort/priority sequences and randomized runs, all checked
//                against a queue-based reference model of window positions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_addr_gen;

    localparam int RC = 4;
    localparam int AW = 8;
    localparam int K  = 3;
    localparam int AL = 9;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     i_reg_clear;
    logic                     i_start;
    logic [AW-1:0]            i_i_size;
    logic [1:0]               i_stride;
    logic                     i_ready;
    logic [0:AL-1][AW-1:0]    o_ag_addr;
    logic                     o_ag_valid;
    logic [RC-1:0]            o_row_id;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_cfg_err;

    int checks = 0;
    int errors = 0;
    int exp_bases[$];

    always #5 i_clk = ~i_clk;

    window_addr_gen #(
        .ROUTER_COUNT (RC),
        .ADDR_WIDTH   (AW),
        .KERNEL_SIZE  (K),
        .ADDR_LENGTH  (AL)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_reg_clear (i_reg_clear),
        .i_start     (i_start),
        .i_i_size    (i_i_size),
        .i_stride    (i_stride),
        .i_ready     (i_ready),
        .o_ag_addr   (o_ag_addr),
        .o_ag_valid  (o_ag_valid),
        .o_row_id    (o_row_id),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One complete run. mode: 0 = always ready, 1 = ready toggles every two
    // cycles, 2 = random ready. abort_kind: 0 none, 1 i_rst, 2 i_reg_clear,
    // applied right after the abort_after-th accept.
    task automatic run(input int I, input int S, input int mode, input int hold,
                       input int abort_kind, input int abort_after,
                       output int n_acc, output int first_base, output int last_base,
                       output int last_row, output int err);
        bit                    ok;
        bit                    rdy;
        bit                    prev_stall;
        bit                    prev_acc_more;
        bit                    done_seen;
        int                    cyc;
        int                    last_acc_cyc;
        int                    budget;
        logic [0:AL-1][AW-1:0] held_addr;
        logic [RC-1:0]         held_row;

        // Reference: every window corner whose KxK footprint fits in the tile.
        exp_bases.delete();
        ok = (S != 0) && (I >= K) && (I * I <= (1 << AW));
        if (ok) begin
            for (int r = 0; r + K <= I; r += S)
                for (int c = 0; c + K <= I; c += S)
                    exp_bases.push_back(r * I + c);
        end
        n_acc = 0; first_base = -1; last_base = -1; last_row = -1;
        last_acc_cyc = -10;

        i_i_size = AW'(I);
        i_stride = 2'(S);
        i_start  = 1'b1;
        tick();
        if (hold == 0) i_start = 1'b0;
        err = int'(o_cfg_err);
        chk("start_valid_low", o_ag_valid, 0);
        chk("start_cfg_err", o_cfg_err, !ok);
        if (!ok) begin
            chk("err_done_pulse", o_done, 1);
            chk("err_busy", o_busy, 0);
            tick();
            i_start = 1'b0;
            chk("err_done_once", o_done, 0);
            chk("err_sticky", o_cfg_err, 1);
            chk("err_no_valid", o_ag_valid, 0);
            return;
        end
        chk("start_busy", o_busy, 1);
        tick();
        chk("first_valid", o_ag_valid, 1);

        cyc = 0; prev_stall = 0; prev_acc_more = 0; done_seen = 0;
        budget = 4 * exp_bases.size() + 20;
        while (cyc < budget) begin
            if (abort_kind != 0 && n_acc == abort_after) begin
                if (abort_kind == 1) i_rst = 1'b1; else i_reg_clear = 1'b1;
                i_ready = 1'b1;
                tick();
                i_rst = 1'b0; i_reg_clear = 1'b0;
                chk("abort_valid", o_ag_valid, 0);
                chk("abort_busy", o_busy, 0);
                chk("abort_row_id", o_row_id, 0);
                chk("abort_no_done", o_done, 0);
                tick();
                chk("abort_no_done_later", o_done, 0);
                chk("abort_idle", o_busy, 0);
                return;
            end
            if (o_done) begin
                done_seen = 1;
                break;
            end
            if (prev_stall || prev_acc_more) chk("valid_held", o_ag_valid, 1);
            if (prev_stall) begin
                for (int k = 0; k < AL; k++) chk("stall_addr", o_ag_addr[k], held_addr[k]);
                chk("stall_row_id", o_row_id, held_row);
            end
            prev_stall = 0; prev_acc_more = 0;
            if (o_ag_valid) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ((cyc / 2) % 2) == 1;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                i_ready = rdy;
                if (rdy) begin
                    if (n_acc < exp_bases.size()) begin
                        for (int k = 0; k < AL; k++)
                            chk("win_addr", o_ag_addr[k], exp_bases[n_acc] + (k / K) * I + (k % K));
                        chk("row_id", o_row_id, n_acc % RC);
                    end else begin
                        chk("extra_window", n_acc, exp_bases.size());
                    end
                    if (n_acc == 0) first_base = int'(o_ag_addr[0]);
                    last_base = int'(o_ag_addr[0]);
                    last_row  = int'(o_row_id);
                    n_acc++;
                    last_acc_cyc = cyc;
                    prev_acc_more = (n_acc < exp_bases.size());
                end else begin
                    prev_stall = 1;
                    held_addr  = o_ag_addr;
                    held_row   = o_row_id;
                end
            end else begin
                i_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end

        if (!done_seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("accept_count", n_acc, exp_bases.size());
            chk("done_timing", cyc, last_acc_cyc + 1);
            chk("done_valid_low", o_ag_valid, 0);
            chk("done_busy_low", o_busy, 0);
            tick();
            chk("done_once", o_done, 0);
            chk("idle_busy_low", o_busy, 0);
            chk("idle_valid_low", o_ag_valid, 0);
        end
        i_start = 1'b0;
    endtask

    typedef struct {
        int I;
        int S;
        int mode;
        int hold;
        int exp_n;
        int exp_err;
        int exp_first;
        int exp_last;
        int exp_last_row;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, fb, lb, lr, er;

        tbl[0] = '{5, 1, 0, 0,   9, 0,  0,  12,  0};
        tbl[1] = '{5, 2, 0, 0,   4, 0,  0,  12,  3};
        tbl[2] = '{6, 2, 0, 0,   4, 0,  0,  14,  3};
        tbl[3] = '{5, 1, 1, 0,   9, 0,  0,  12,  0};
        tbl[4] = '{2, 1, 0, 0,   0, 1, -1,  -1, -1};
        tbl[5] = '{17, 1, 0, 0,  0, 1, -1,  -1, -1};
        tbl[6] = '{16, 1, 0, 0, 196, 0, 0, 221,  3};
        tbl[7] = '{5, 0, 0, 0,   0, 1, -1,  -1, -1};
        tbl[8] = '{3, 3, 0, 0,   1, 0,  0,   0,  0};
        tbl[9] = '{7, 3, 2, 1,   4, 0,  0,  24,  3};

        i_rst = 1'b1; i_reg_clear = 1'b0; i_start = 1'b0;
        i_i_size = '0; i_stride = '0; i_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", o_ag_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_cfg_err", o_cfg_err, 0);
        chk("reset_row_id", o_row_id, 0);
        chk("reset_addr0", o_ag_addr[0], 0);
        i_rst = 1'b0;
        tick();

        for (int t = 0; t < 10; t++) begin
            run(tbl[t].I, tbl[t].S, tbl[t].mode, tbl[t].hold, 0, 0, n, fb, lb, lr, er);
            chk("tbl_count", n, tbl[t].exp_n);
            chk("tbl_cfg_err", er, tbl[t].exp_err);
            chk("tbl_first_base", fb, tbl[t].exp_first);
            chk("tbl_last_base", lb, tbl[t].exp_last);
            chk("tbl_last_row", lr, tbl[t].exp_last_row);
            tick();
        end

        // Error flag stays set in IDLE until the next start.
        run(2, 1, 0, 0, 0, 0, n, fb, lb, lr, er);
        tick(); tick(); tick();
        chk("cfg_err_sticky_idle", o_cfg_err, 1);
        run(5, 1, 0, 0, 0, 0, n, fb, lb, lr, er);
        chk("cfg_err_cleared", er, 0);
        chk("cfg_err_after_run", o_cfg_err, 0);
        tick();

        // Reset after the 4th accept aborts; the next run restarts cleanly.
        run(5, 1, 0, 0, 1, 4, n, fb, lb, lr, er);
        chk("abort_rst_count", n, 4);
        run(5, 1, 0, 0, 0, 0, n, fb, lb, lr, er);
        chk("rerun_first_base", fb, 0);
        chk("rerun_count", n, 9);
        tick();

        // Soft clear mid-run behaves like reset.
        run(6, 1, 2, 0, 2, 2, n, fb, lb, lr, er);
        chk("abort_clr_count", n, 2);

        // Start and reset on the same edge: reset wins.
        i_i_size = 8'd5; i_stride = 2'd1;
        i_start = 1'b1; i_rst = 1'b1;
        tick();
        i_start = 1'b0; i_rst = 1'b0;
        chk("rst_vs_start_busy", o_busy, 0);
        tick();
        chk("rst_vs_start_valid", o_ag_valid, 0);
        chk("rst_vs_start_idle", o_busy, 0);

        // Randomized configurations and backpressure.
        for (int r = 0; r < 25; r++) begin
            int ri, rs;
            ri = int'($urandom_range(0, 20));
            rs = int'($urandom_range(0, 3));
            run(ri, rs, 2, 0, 0, 0, n, fb, lb, lr, er);
            chk("rand_count", n, exp_bases.size());
            chk("rand_cfg_err", er, (rs == 0 || ri < K || ri * ri > (1 << AW)) ? 1 : 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_window_addr_gen
`default_nettype wire
